// File: rtl/system_mem_v2.sv
// Single-port-address word memory with byte-lane write masks, a 1- or
// 2-cycle registered read path, selectable read-during-write behaviour
// and a one-word-per-cycle zeroize sweep controlled by a small FSM.
// Memory contents are never reset; only control and output state is.
module system_mem_v2 #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 6,
  parameter int RD_LAT  = 1,
  parameter int RDW_NEW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enR,
  input  logic                  enW,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   wmask,
  input  logic [DATA_W-1:0]     mem_input,
  input  logic                  clr,
  output logic [DATA_W-1:0]     mem_output,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   cnt_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   stored;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   rd_word;
  logic                accept;
  logic                rd_fire;
  logic                wr_fire;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;

  // Requests are only taken in IDLE, and a clr in the same cycle drops them.
  assign busy    = (state_q == CLEAR);
  assign accept  = !rst && !busy && !clr;
  assign rd_fire = accept && enR;
  assign wr_fire = accept && enW;
  assign stored  = mem[addr];

  // Build the post-write word: selected lanes from mem_input, the rest kept.
  always_comb begin
    merged = stored;
    for (int i = 0; i < NB; i++) begin
      if (wmask[i]) begin
        merged[8*i +: 8] = mem_input[8*i +: 8];
      end
    end
  end

  assign rd_word = (RDW_NEW != 0 && wr_fire) ? merged : stored;

  // Storage array: the sweep zeroes one word per cycle, otherwise masked writes.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire) begin
      mem[addr] <= merged;
    end
  end

  // State and sweep-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: clr starts a sweep that ends after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr && !rst) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s1_valid;
      logic [DATA_W-1:0] s1_data;

      // Extra pipeline stage; keeps draining even while a sweep runs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
        end else begin
          s1_valid <= rd_fire;
          if (rd_fire) begin
            s1_data <= rd_word;
          end
        end
      end

      assign out_valid = s1_valid;
      assign out_data  = s1_data;
    end else begin : g_lat1
      assign out_valid = rd_fire;
      assign out_data  = rd_word;
    end
  endgenerate

  // Output register: updates only when a read result arrives, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_output <= '0;
      rvalid     <= 1'b0;
    end else begin
      rvalid <= out_valid;
      if (out_valid) begin
        mem_output <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_system_mem_v2.sv
// Bench for system_mem_v2: three instances (latency 1 / old data,
// latency 1 / new data, latency 2 / old data) share one stimulus stream.
// Expected read results go into queues when a read is driven and are
// compared when rvalid is due; a table covers the data-path vectors.
module tb_system_mem_v2;

  typedef struct {
    logic        enR;
    logic        enW;
    logic        clr;
    logic [5:0]  addr;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] exp_old;
    logic [63:0] exp_new;
  } vec_t;

  typedef struct {
    int          due;
    logic [63:0] d_old;
    logic [63:0] d_new;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enR = 1'b0;
  logic        enW = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  addr = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] mem_input = '0;

  logic [63:0] out0, out1, out2;
  logic        rv0, rv1, rv2;
  logic        busy0, busy1, busy2;

  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] mm [64];
  int          sweep_left = 0;
  int          sweep_addr = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  vec_t        tab[$];

  system_mem_v2 #(.DATA_W(64), .ADDR_W(6), .RD_LAT(1), .RDW_NEW(0)) dut0 (
    .clk(clk), .rst(rst), .enR(enR), .enW(enW), .addr(addr), .wmask(wmask),
    .mem_input(mem_input), .clr(clr), .mem_output(out0), .rvalid(rv0), .busy(busy0));

  system_mem_v2 #(.DATA_W(64), .ADDR_W(6), .RD_LAT(1), .RDW_NEW(1)) dut1 (
    .clk(clk), .rst(rst), .enR(enR), .enW(enW), .addr(addr), .wmask(wmask),
    .mem_input(mem_input), .clr(clr), .mem_output(out1), .rvalid(rv1), .busy(busy1));

  system_mem_v2 #(.DATA_W(64), .ADDR_W(6), .RD_LAT(2), .RDW_NEW(0)) dut2 (
    .clk(clk), .rst(rst), .enR(enR), .enW(enW), .addr(addr), .wmask(wmask),
    .mem_input(mem_input), .clr(clr), .mem_output(out2), .rvalid(rv2), .busy(busy2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [5:0] a,
                              input logic [7:0] m, input logic [63:0] d,
                              input logic [63:0] eo, input logic [63:0] en);
    vec_t v;
    v.enR = r; v.enW = w; v.clr = 1'b0; v.addr = a; v.wmask = m; v.wdata = d;
    v.exp_old = eo; v.exp_new = en;
    return v;
  endfunction

  function automatic logic [63:0] mergeWord(input logic [63:0] old, input logic [63:0] d,
                                            input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One call drives one clock cycle and updates the reference model.
  task automatic applyStimulus(input vec_t v, input bit use_tab);
    exp_t        e;
    logic [63:0] nw;
    @(negedge clk);
    checkOutput("busy0", busy0, (sweep_left > 0));
    checkOutput("busy1", busy1, (sweep_left > 0));
    checkOutput("busy2", busy2, (sweep_left > 0));
    enR = v.enR; enW = v.enW; clr = v.clr; addr = v.addr;
    wmask = v.wmask; mem_input = v.wdata;
    if (sweep_left > 0) begin
      mm[sweep_addr] = '0;
      sweep_addr++;
      sweep_left--;
    end else if (v.clr) begin
      sweep_left = 64;
      sweep_addr = 0;
    end else begin
      nw = mergeWord(mm[v.addr], v.wdata, v.wmask);
      if (v.enR) begin
        e.d_old = use_tab ? v.exp_old : mm[v.addr];
        e.d_new = use_tab ? v.exp_new : (v.enW ? nw : mm[v.addr]);
        e.due = cyc + 1;
        qa.push_back(e);
        e.due = cyc + 2;
        qb.push_back(e);
      end
      if (v.enW) mm[v.addr] = nw;
    end
  endtask

  task automatic idle(input int n);
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) applyStimulus(v, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; enR = 0; enW = 0; clr = 0;
    qa.delete();
    qb.delete();
    sweep_left = 0;
    #1;
    checkOutput("rst_busy0", busy0, 0);
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_busy2", busy2, 0);
    checkOutput("rst_rvalid0", rv0, 0);
    checkOutput("rst_rvalid1", rv1, 0);
    checkOutput("rst_rvalid2", rv2, 0);
    checkOutput("rst_out0", out0, 0);
    checkOutput("rst_out1", out1, 0);
    checkOutput("rst_out2", out2, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Result monitor: compares due entries, otherwise requires rvalid low.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        checkOutput("rvalid_lat1_old", rv0, 1);
        checkOutput("rvalid_lat1_new", rv1, 1);
        checkOutput("data_lat1_old", out0, e.d_old);
        checkOutput("data_lat1_new", out1, e.d_new);
      end else begin
        checkOutput("no_rvalid_lat1_old", rv0, 0);
        checkOutput("no_rvalid_lat1_new", rv1, 0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front();
        checkOutput("rvalid_lat2", rv2, 1);
        checkOutput("data_lat2", out2, e.d_old);
      end else begin
        checkOutput("no_rvalid_lat2", rv2, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;

    // Data-path vectors: inputs plus the read result each DUT must return.
    tab.push_back(mk(0, 1, 5, 8'hFF, 64'h0123456789ABCDEF, 0, 0));
    tab.push_back(mk(1, 0, 5, 8'h00, 0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF));
    tab.push_back(mk(0, 1, 5, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 0, 0));
    tab.push_back(mk(1, 0, 5, 8'h00, 0, 64'h01234567FFFFFFFF, 64'h01234567FFFFFFFF));
    tab.push_back(mk(0, 1, 3, 8'hFF, 64'h11, 0, 0));
    tab.push_back(mk(1, 1, 3, 8'hFF, 64'h22, 64'h11, 64'h22));
    tab.push_back(mk(1, 0, 3, 8'h00, 0, 64'h22, 64'h22));
    tab.push_back(mk(0, 1, 7, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 0, 0));
    tab.push_back(mk(0, 1, 7, 8'h00, 64'h5555555555555555, 0, 0));
    tab.push_back(mk(1, 1, 7, 8'h00, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA));
    tab.push_back(mk(1, 0, 9, 8'h00, 0, 64'h1919191919191919, 64'h1919191919191919));
    tab.push_back(mk(1, 1, 10, 8'hFF, 64'hBBBBBBBBBBBBBBBB, 64'h1A1A1A1A1A1A1A1A, 64'hBBBBBBBBBBBBBBBB));
    tab.push_back(mk(1, 0, 10, 8'h00, 0, 64'hBBBBBBBBBBBBBBBB, 64'hBBBBBBBBBBBBBBBB));
    tab.push_back(mk(1, 1, 12, 8'h81, 64'hFFFFFFFFFFFFFFFF, 64'h1C1C1C1C1C1C1C1C, 64'hFF1C1C1C1C1C1CFF));
    tab.push_back(mk(1, 0, 12, 8'h00, 0, 64'hFF1C1C1C1C1C1CFF, 64'hFF1C1C1C1C1C1CFF));
    tab.push_back(mk(1, 0, 1, 8'h00, 0, 64'h1111111111111111, 64'h1111111111111111));
    tab.push_back(mk(1, 0, 2, 8'h00, 0, 64'h1212121212121212, 64'h1212121212121212));
    tab.push_back(mk(1, 0, 3, 8'h00, 0, 64'h22, 64'h22));

    // Power-on reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("por_busy0", busy0, 0);
    checkOutput("por_rvalid0", rv0, 0);
    checkOutput("por_out0", out0, 0);
    checkOutput("por_out2", out2, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill every word with a known nonzero pattern.
    for (int a = 0; a < 64; a++) begin
      v = mk(0, 1, 6'(a), 8'hFF, {8{8'(a + 16)}}, 0, 0);
      applyStimulus(v, 0);
    end

    $display("[TB] applying %0d table vectors", tab.size());
    for (int i = 0; i < tab.size(); i++) applyStimulus(tab[i], 1);
    idle(3);

    // Read just before clr must still complete; clr-cycle read/write dropped.
    applyStimulus(mk(1, 0, 20, 8'h00, 0, 0, 0), 0);
    v = mk(1, 1, 20, 8'hFF, 64'hDEADBEEFDEADBEEF, 0, 0);
    v.clr = 1'b1;
    applyStimulus(v, 0);
    for (int i = 0; i < 64; i++) begin
      v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
             8'hFF, 64'hCAFECAFECAFECAFE, 0, 0);
      v.clr = 1'($urandom_range(0, 1));
      applyStimulus(v, 0);
    end
    // Requests on the cycle busy falls are taken.
    applyStimulus(mk(1, 0, 0, 8'h00, 0, 0, 0), 0);
    applyStimulus(mk(1, 0, 63, 8'h00, 0, 0, 0), 0);
    applyStimulus(mk(1, 0, 20, 8'h00, 0, 0, 0), 0);
    idle(3);

    // Refill, leave a nonzero output, start a sweep and reset 10 cycles in.
    for (int a = 0; a < 64; a++) begin
      v = mk(0, 1, 6'(a), 8'hFF, {8{8'(a + 128)}}, 0, 0);
      applyStimulus(v, 0);
    end
    applyStimulus(mk(1, 0, 40, 8'h00, 0, 0, 0), 0);
    idle(2);
    v = mk(0, 0, 0, 8'h00, 0, 0, 0);
    v.clr = 1'b1;
    applyStimulus(v, 0);
    idle(10);
    doReset();
    for (int a = 0; a < 13; a++) applyStimulus(mk(1, 0, 6'(a), 8'h00, 0, 0, 0), 0);
    applyStimulus(mk(1, 0, 63, 8'h00, 0, 0, 0), 0);
    idle(4);

    checkOutput("queue_lat1_drained", 64'(qa.size()), 0);
    checkOutput("queue_lat2_drained", 64'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
